// File: rtl/sync_fifo_pkg.sv
// Shared constants, operation encoding and sizing helpers for the synchronous FIFO.
package sync_fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;

   // Encoding is {write accepted, read accepted}.
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 4) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one synchronous write port, one asynchronous read port.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic [addr_width(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]             wr_word,
   input  logic [addr_width(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]             rd_word
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; validity is tracked by the pointers and count, so clearing it would only cost logic.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_word;
      end
   end

   // Reads see the pre-edge contents, so a same-edge write to the head slot cannot corrupt the popped word.
   assign rd_word = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count, almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wrt_enable,
   input  logic                          rd_enable,
   input  logic [WIDTH-1:0]              data,
   output logic [WIDTH-1:0]              data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW = addr_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   if (!depth_ok(DEPTH) || (WIDTH < 1)) begin : g_param_check
      $error("sync_fifo: DEPTH must be a power of two >= 4 and WIDTH >= 1");
   end

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_acc;
   logic             wr_acc;
   logic [WIDTH-1:0] head;
   fifo_op_e         op;

   // A pop frees a slot on the same edge, so a full FIFO still takes a write alongside a read.
   always_comb begin
      rd_acc = rd_enable && !empty;
      wr_acc = wrt_enable && (!full || rd_acc);
      op     = fifo_op_e'({wr_acc, rd_acc});
   end

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AFULL_LVL));
   assign almost_empty = (count <= CW'(AEMPTY_LVL));

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case (op)
            OP_WRITE: count <= count + CW'(1);
            OP_READ:  count <= count - CW'(1);
            default:  count <= count;
         endcase
         overflow  <= wrt_enable && !wr_acc;
         underflow <= rd_enable && empty;
      end
   end

   sync_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_word (data),
      .rd_addr (rd_ptr),
      .rd_word (head)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head slot is already valid whenever count is non-zero; present zero when nothing is stored.
   assign data_out = empty ? '0 : head;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
      end else if (rd_acc) begin
         data_out <= head;
      end
   end
`endif

endmodule
